// File: rtl/pifo_calendar_v0_2_if.sv
// Insert (s_axis) and pop (m_axis) handshake bundle for the PIFO calendar.
// The slave modport is the calendar side. The master modport is the producer/consumer side.
interface pifo_calendar_v0_2_if #(
  parameter int RANK_WIDTH = 19,
  parameter int DATA_WIDTH = 12
);
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [RANK_WIDTH-1:0] s_axis_trank;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [RANK_WIDTH-1:0] m_axis_trank;
  logic [DATA_WIDTH-1:0] m_axis_tdata;

  modport slave (
    input  s_axis_tvalid, s_axis_trank, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_trank, m_axis_tdata
  );

  modport master (
    output s_axis_tvalid, s_axis_trank, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_trank, m_axis_tdata
  );
endinterface

// File: rtl/pifo_calendar_v0_2.sv
// Single-level PIFO calendar: a shift-register slot array kept sorted by ascending rank.
// Ties are broken FIFO. The queue supports same-cycle insert/pop, flush, and a reject-new or evict-tail policy when full.
module pifo_calendar_v0_2 #(
  parameter int DEPTH          = 64,
  parameter int COUNT_WIDTH    = 7,
  parameter int RANK_WIDTH     = 19,
  parameter int DATA_WIDTH     = 12,
  parameter int DROP_MODE      = 0,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  pifo_calendar_v0_2_if.slave       axis,
  input  logic                      flush,
  output logic [COUNT_WIDTH-1:0]    occupancy,
  output logic                      full,
  output logic                      empty,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [COUNT_WIDTH-1:0] DEPTH_CNT = COUNT_WIDTH'(DEPTH);

  logic [DEPTH-1:0]          valid_reg;
  logic [RANK_WIDTH-1:0]     rank_reg [DEPTH];
  logic [DATA_WIDTH-1:0]     data_reg [DEPTH];
  logic [COUNT_WIDTH-1:0]    count_reg, count_next;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg, drop_cnt_next;

  // post_* is the list after an optional pop; *_next is that list after an optional insert
  logic [DEPTH-1:0]          post_valid;
  logic [RANK_WIDTH-1:0]     post_rank [DEPTH];
  logic [DATA_WIDTH-1:0]     post_data [DEPTH];
  logic [DEPTH-1:0]          behind;
  logic [DEPTH-1:0]          take_new;
  logic [DEPTH-1:0]          shift_in;
  logic [DEPTH-1:0]          valid_next;
  logic [RANK_WIDTH-1:0]     rank_next [DEPTH];
  logic [DATA_WIDTH-1:0]     data_next [DEPTH];

  logic insert_fire;
  logic pop_fire;

  assign occupancy          = count_reg;
  assign full               = (count_reg == DEPTH_CNT);
  assign empty              = (count_reg == '0);
  assign drop_cnt           = drop_cnt_reg;
  assign axis.s_axis_tready = (DROP_MODE != 0) ? 1'b1 : !full;
  assign axis.m_axis_tvalid = valid_reg[0];
  assign axis.m_axis_trank  = rank_reg[0];
  assign axis.m_axis_tdata  = data_reg[0];

  assign insert_fire = axis.s_axis_tvalid & axis.s_axis_tready;
  assign pop_fire    = valid_reg[0] & axis.m_axis_tready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == DEPTH - 1) begin : g_tail_pop
        assign post_valid[gi] = pop_fire ? 1'b0 : valid_reg[gi];
        assign post_rank[gi]  = pop_fire ? '0 : rank_reg[gi];
        assign post_data[gi]  = pop_fire ? '0 : data_reg[gi];
      end else begin : g_body_pop
        assign post_valid[gi] = pop_fire ? valid_reg[gi+1] : valid_reg[gi];
        assign post_rank[gi]  = pop_fire ? rank_reg[gi+1]  : rank_reg[gi];
        assign post_data[gi]  = pop_fire ? data_reg[gi+1]  : data_reg[gi];
      end

      // Monotone across slots because the list is sorted; strict > gives the FIFO tie-break
      assign behind[gi] = !post_valid[gi] || (post_rank[gi] > axis.s_axis_trank);

      if (gi == 0) begin : g_head_ins
        assign take_new[gi]   = insert_fire && behind[gi];
        assign shift_in[gi]   = 1'b0;
        assign valid_next[gi] = take_new[gi] ? 1'b1 : post_valid[gi];
        assign rank_next[gi]  = take_new[gi] ? axis.s_axis_trank : post_rank[gi];
        assign data_next[gi]  = take_new[gi] ? axis.s_axis_tdata : post_data[gi];
      end else begin : g_body_ins
        assign take_new[gi]   = insert_fire && behind[gi] && !behind[gi-1];
        assign shift_in[gi]   = insert_fire && behind[gi] && behind[gi-1];
        assign valid_next[gi] = take_new[gi] ? 1'b1 :
                                shift_in[gi] ? post_valid[gi-1] : post_valid[gi];
        assign rank_next[gi]  = take_new[gi] ? axis.s_axis_trank :
                                shift_in[gi] ? post_rank[gi-1] : post_rank[gi];
        assign data_next[gi]  = take_new[gi] ? axis.s_axis_tdata :
                                shift_in[gi] ? post_data[gi-1] : post_data[gi];
      end
    end
  endgenerate

  // A full queue with insert and no pop is either an eviction or a rejection; both count as one drop
  always_comb begin
    count_next    = count_reg;
    drop_cnt_next = drop_cnt_reg;
    if (insert_fire && !pop_fire) begin
      if (full) begin
        if (!(&drop_cnt_reg)) drop_cnt_next = drop_cnt_reg + 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (pop_fire && !insert_fire) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rank_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else if (flush) begin
      valid_reg <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rank_reg[i] <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg    <= valid_next;
      count_reg    <= count_next;
      drop_cnt_reg <= drop_cnt_next;
      for (int i = 0; i < DEPTH; i++) begin
        rank_reg[i] <= rank_next[i];
        data_reg[i] <= data_next[i];
      end
    end
  end

endmodule

// File: tb/tb_pifo_calendar_v0_2.sv
// Directed bench for pifo_calendar_v0_2 across three configurations, with a per-instance pop scoreboard.
// Instance a: DEPTH=8, reject mode. Instance b: DEPTH=4, reject mode. Instance c: DEPTH=4, evict mode.
module tb_pifo_calendar_v0_2;

  typedef struct packed {
    logic [18:0] r;
    logic [11:0] d;
  } exp_t;

  logic clk;
  logic rst;
  logic flush_a, flush_b, flush_c;
  logic [6:0]  occ_a, occ_b, occ_c;
  logic        full_a, full_b, full_c;
  logic        empty_a, empty_b, empty_c;
  logic [15:0] drop_a, drop_b, drop_c;

  int tests;
  int failed;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  pifo_calendar_v0_2_if #(.RANK_WIDTH(19), .DATA_WIDTH(12)) ia ();
  pifo_calendar_v0_2_if #(.RANK_WIDTH(19), .DATA_WIDTH(12)) ib ();
  pifo_calendar_v0_2_if #(.RANK_WIDTH(19), .DATA_WIDTH(12)) ic ();

  pifo_calendar_v0_2 #(.DEPTH(8), .DROP_MODE(0)) u_a (
    .clk(clk), .rst(rst), .axis(ia), .flush(flush_a),
    .occupancy(occ_a), .full(full_a), .empty(empty_a), .drop_cnt(drop_a)
  );
  pifo_calendar_v0_2 #(.DEPTH(4), .DROP_MODE(0)) u_b (
    .clk(clk), .rst(rst), .axis(ib), .flush(flush_b),
    .occupancy(occ_b), .full(full_b), .empty(empty_b), .drop_cnt(drop_b)
  );
  pifo_calendar_v0_2 #(.DEPTH(4), .DROP_MODE(1)) u_c (
    .clk(clk), .rst(rst), .axis(ic), .flush(flush_c),
    .occupancy(occ_c), .full(full_c), .empty(empty_c), .drop_cnt(drop_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: a pop fires on the next rising edge when valid & ready at the falling edge
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst && ia.m_axis_tvalid && ia.m_axis_tready) begin
      $display("[TB] a pop rank=%0d data=%0h", ia.m_axis_trank, ia.m_axis_tdata);
      if (q_a.size() == 0) cmp("a_unexpected_pop", 1, 0);
      else begin
        e = q_a.pop_front();
        cmp("a_pop_rank", 32'(ia.m_axis_trank), 32'(e.r));
        cmp("a_pop_data", 32'(ia.m_axis_tdata), 32'(e.d));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst && ib.m_axis_tvalid && ib.m_axis_tready) begin
      $display("[TB] b pop rank=%0d data=%0h", ib.m_axis_trank, ib.m_axis_tdata);
      if (q_b.size() == 0) cmp("b_unexpected_pop", 1, 0);
      else begin
        e = q_b.pop_front();
        cmp("b_pop_rank", 32'(ib.m_axis_trank), 32'(e.r));
        cmp("b_pop_data", 32'(ib.m_axis_tdata), 32'(e.d));
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (!rst && ic.m_axis_tvalid && ic.m_axis_tready) begin
      $display("[TB] c pop rank=%0d data=%0h", ic.m_axis_trank, ic.m_axis_tdata);
      if (q_c.size() == 0) cmp("c_unexpected_pop", 1, 0);
      else begin
        e = q_c.pop_front();
        cmp("c_pop_rank", 32'(ic.m_axis_trank), 32'(e.r));
        cmp("c_pop_data", 32'(ic.m_axis_tdata), 32'(e.d));
      end
    end
  end

  task automatic expect_pop(input int sel, input logic [18:0] r, input logic [11:0] d);
    exp_t e;
    e.r = r;
    e.d = d;
    case (sel)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic drive_ins(input int sel, input logic v, input logic [18:0] r, input logic [11:0] d);
    case (sel)
      0: begin ia.s_axis_tvalid = v; ia.s_axis_trank = r; ia.s_axis_tdata = d; end
      1: begin ib.s_axis_tvalid = v; ib.s_axis_trank = r; ib.s_axis_tdata = d; end
      default: begin ic.s_axis_tvalid = v; ic.s_axis_trank = r; ic.s_axis_tdata = d; end
    endcase
  endtask

  task automatic drive_pop(input int sel, input logic v);
    case (sel)
      0: ia.m_axis_tready = v;
      1: ib.m_axis_tready = v;
      default: ic.m_axis_tready = v;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input int sel, input logic [18:0] r, input logic [11:0] d);
    $display("[TB] inst %0d insert rank=%0d data=%0h", sel, r, d);
    drive_ins(sel, 1'b1, r, d);
    step();
    drive_ins(sel, 1'b0, '0, '0);
  endtask

  task automatic pops(input int sel, input int n);
    drive_pop(sel, 1'b1);
    repeat (n) step();
    drive_pop(sel, 1'b0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    {flush_a, flush_b, flush_c} = '0;
    for (int s = 0; s < 3; s++) begin
      drive_ins(s, 1'b0, '0, '0);
      drive_pop(s, 1'b0);
    end
    repeat (2) step();

    // Reset state
    cmp("rst_empty", 32'(empty_a), 1);
    cmp("rst_full", 32'(full_a), 0);
    cmp("rst_occ", 32'(occ_a), 0);
    cmp("rst_tvalid", 32'(ia.m_axis_tvalid), 0);
    cmp("rst_tready", 32'(ia.s_axis_tready), 1);
    cmp("rst_drop", 32'(drop_c), 0);
    rst = 1'b0;
    step();

    // Sorted order
    expect_pop(0, 10, 12'h2);
    expect_pop(0, 30, 12'h3);
    expect_pop(0, 50, 12'h1);
    ins(0, 50, 12'h1);
    cmp("t1_head_latency", 32'(ia.m_axis_trank), 50);
    ins(0, 10, 12'h2);
    ins(0, 30, 12'h3);
    cmp("t1_occ", 32'(occ_a), 3);
    pops(0, 3);
    cmp("t1_empty", 32'(empty_a), 1);

    // FIFO tie-break on equal rank
    expect_pop(0, 20, 12'hA);
    expect_pop(0, 20, 12'hB);
    ins(0, 20, 12'hA);
    ins(0, 20, 12'hB);
    pops(0, 2);

    // Same-cycle insert and pop
    expect_pop(0, 10, 12'h10);
    expect_pop(0, 5, 12'h55);
    for (int k = 2; k <= 5; k++) expect_pop(0, 19'(k * 10), 12'(k * 16));
    for (int k = 1; k <= 5; k++) ins(0, 19'(k * 10), 12'(k * 16));
    drive_ins(0, 1'b1, 5, 12'h55);
    drive_pop(0, 1'b1);
    step();
    drive_ins(0, 1'b0, '0, '0);
    drive_pop(0, 1'b0);
    cmp("t3_occ", 32'(occ_a), 5);
    cmp("t3_head_rank", 32'(ia.m_axis_trank), 5);
    pops(0, 5);
    cmp("t3_empty", 32'(empty_a), 1);

    // Reject-when-full backpressure
    expect_pop(1, 1, 12'h1);
    expect_pop(1, 0, 12'hE);
    for (int k = 2; k <= 4; k++) expect_pop(1, 19'(k), 12'(k));
    for (int k = 1; k <= 4; k++) ins(1, 19'(k), 12'(k));
    cmp("t4_full", 32'(full_b), 1);
    cmp("t4_tready_low", 32'(ib.s_axis_tready), 0);
    drive_ins(1, 1'b1, 0, 12'hE);
    repeat (3) step();
    cmp("t4_drop_zero", 32'(drop_b), 0);
    cmp("t4_occ_held", 32'(occ_b), 4);
    drive_pop(1, 1'b1);
    step();
    drive_pop(1, 1'b0);
    cmp("t4_tready_high", 32'(ib.s_axis_tready), 1);
    cmp("t4_occ_after_pop", 32'(occ_b), 3);
    step();
    drive_ins(1, 1'b0, '0, '0);
    cmp("t4_occ_accepted", 32'(occ_b), 4);
    cmp("t4_head", 32'(ib.m_axis_trank), 0);
    pops(1, 4);

    // Evict-tail policy
    for (int k = 1; k <= 3; k++) expect_pop(2, 19'(k), 12'(k));
    expect_pop(2, 5, 12'h5);
    ins(2, 1, 12'h1);
    ins(2, 2, 12'h2);
    ins(2, 3, 12'h3);
    ins(2, 8, 12'h8);
    cmp("t5_full", 32'(full_c), 1);
    ins(2, 5, 12'h5);
    cmp("t5_drop_evict", 32'(drop_c), 1);
    cmp("t5_occ", 32'(occ_c), 4);
    ins(2, 9, 12'h9);
    cmp("t5_drop_reject", 32'(drop_c), 2);
    ins(2, 5, 12'h6);
    cmp("t5_drop_equal", 32'(drop_c), 3);
    cmp("t5_tready", 32'(ic.s_axis_tready), 1);
    pops(2, 4);
    cmp("t5_empty", 32'(empty_c), 1);

    // Flush beats a same-cycle insert; drop count survives
    ins(2, 4, 12'h4);
    ins(2, 6, 12'h6);
    ins(2, 7, 12'h7);
    drive_ins(2, 1'b1, 1, 12'hF);
    flush_c = 1'b1;
    step();
    flush_c = 1'b0;
    drive_ins(2, 1'b0, '0, '0);
    cmp("t6_flush_empty", 32'(empty_c), 1);
    cmp("t6_flush_occ", 32'(occ_c), 0);
    cmp("t6_flush_tvalid", 32'(ic.m_axis_tvalid), 0);
    cmp("t6_flush_drop", 32'(drop_c), 3);

    // Asynchronous reset in the middle of an insert
    ins(2, 11, 12'hB);
    ins(2, 12, 12'hC);
    drive_ins(2, 1'b1, 13, 12'hD);
    #3;
    rst = 1'b1;
    #1;
    cmp("t6_rst_occ", 32'(occ_c), 0);
    cmp("t6_rst_empty", 32'(empty_c), 1);
    cmp("t6_rst_full", 32'(full_c), 0);
    cmp("t6_rst_tvalid", 32'(ic.m_axis_tvalid), 0);
    cmp("t6_rst_trank", 32'(ic.m_axis_trank), 0);
    cmp("t6_rst_tdata", 32'(ic.m_axis_tdata), 0);
    cmp("t6_rst_drop", 32'(drop_c), 0);
    cmp("t6_rst_tready", 32'(ic.s_axis_tready), 1);
    drive_ins(2, 1'b0, '0, '0);
    step();
    rst = 1'b0;
    step();

    cmp("a_queue_drained", 32'(q_a.size()), 0);
    cmp("b_queue_drained", 32'(q_b.size()), 0);
    cmp("c_queue_drained", 32'(q_c.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
